// File: rtl/io_int_responder.sv
// rtl/io_int_responder.sv - device-side I/O and interrupt responder with word FIFO (optional drop-on-timeout via IO_TIMEOUT_EN)
module io_int_responder #(
    parameter int DEPTH   = 4,
    parameter int PTR_W   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      ext_data,
    input  logic             ext_valid,
    output logic             ext_ready,
    output logic [15:0]      data_in,
    output logic             interrupt,
    input  logic             int_ack,
    input  logic [15:0]      data_out,
    input  logic             out_we,
    output logic [15:0]      out_data,
    output logic             out_valid,
    output logic [PTR_W:0]   fifo_count,
    output logic             overflow,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [PTR_W:0] L_FULL = (PTR_W + 1)'(DEPTH);

    state_t           r_state;
    state_t           w_next_state;

    logic [15:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic [15:0]      r_data_in;
    logic             r_interrupt;
    logic [15:0]      r_out_data;
    logic             r_out_valid;
    logic             r_overflow;

    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_load;
    logic             w_tmo_hit;

    // Readiness depends only on the current count, so a pop in the same cycle
    // never makes room for a push that arrives while full.
    assign w_full = (r_count == L_FULL);
    assign w_push = ext_valid && !w_full;
    assign w_pop  = (r_state == ST_REQ) && (int_ack || w_tmo_hit);

    assign ext_ready  = !w_full;
    assign fifo_count = r_count;
    assign data_in    = r_data_in;
    assign interrupt  = r_interrupt;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign overflow   = r_overflow;

    // FIFO storage; buffered words are discarded on reset by clearing the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ext_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flag for pushes refused because the FIFO was full
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (ext_valid && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    // Delivery state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Delivery next state: IDLE fetches the head, REQ waits for ack, GAP keeps interrupt low one extra cycle
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_next_state = ST_REQ;
                    w_load       = 1'b1;
                end
            end
            ST_REQ: begin
                if (int_ack || w_tmo_hit) begin
                    w_next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Registered request and word presented to the core; data_in holds outside REQ
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_interrupt <= 1'b0;
            r_data_in   <= '0;
        end else begin
            r_interrupt <= (w_next_state == ST_REQ);
            if (w_load) begin
                r_data_in <= r_mem[r_rd_ptr];
            end
        end
    end

    // Core write port, independent of delivery; last write wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= out_we;
            if (out_we) begin
                r_out_data <= data_out;
            end
        end
    end

`ifdef IO_TIMEOUT_EN
    localparam int              TMO_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] L_TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_timeout_err;

    // The drop fires in the TIMEOUT-th unacknowledged REQ cycle; an ack in that cycle wins
    assign w_tmo_hit   = (r_state == ST_REQ) && !int_ack && (r_tmo_cnt == L_TMO_LAST);
    assign timeout_err = r_timeout_err;

    // Cycles spent waiting in REQ, restarted on every entry into REQ
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt <= '0;
        end else if (w_load) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ST_REQ) && !int_ack) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Sticky flag for words dropped without acknowledgement
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timeout_err <= 1'b0;
        end else if (w_tmo_hit) begin
            r_timeout_err <= 1'b1;
        end
    end
`else
    // Without the counter REQ waits indefinitely; TIMEOUT has no effect here
    assign w_tmo_hit   = 1'b0;
    assign timeout_err = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_io_int_responder.sv
// tb/tb_io_int_responder.sv - self-checking bench for io_int_responder against a queue-based reference model
module tb_io_int_responder;

    localparam int DEPTH   = 4;
    localparam int PTR_W   = 2;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [15:0]      ext_data;
    logic             ext_valid;
    logic             ext_ready;
    logic [15:0]      data_in;
    logic             interrupt;
    logic             int_ack;
    logic [15:0]      data_out;
    logic             out_we;
    logic [15:0]      out_data;
    logic             out_valid;
    logic [PTR_W:0]   fifo_count;
    logic             overflow;
    logic             timeout_err;

    io_int_responder #(
        .DEPTH   (DEPTH),
        .PTR_W   (PTR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ext_data    (ext_data),
        .ext_valid   (ext_valid),
        .ext_ready   (ext_ready),
        .data_in     (data_in),
        .interrupt   (interrupt),
        .int_ack     (int_ack),
        .data_out    (data_out),
        .out_we      (out_we),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [15:0] q[$];
    bit          m_req;
    int          m_cool;
    int          m_wait;
    logic [15:0] m_data_in;
    bit          m_ovf;
    bit          m_tmo;
    bit          m_ov;
    logic [15:0] m_od;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_req     = 1'b0;
        m_cool    = 0;
        m_wait    = 0;
        m_data_in = '0;
        m_ovf     = 1'b0;
        m_tmo     = 1'b0;
        m_ov      = 1'b0;
        m_od      = '0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit push;
        push = ext_valid && (q.size() < DEPTH);
        if (ext_valid && (q.size() == DEPTH)) m_ovf = 1'b1;
        m_ov = out_we;
        if (out_we) m_od = data_out;
        if (m_req) begin
            if (int_ack) begin
                void'(q.pop_front());
                m_req  = 1'b0;
                m_cool = 1;
            end
`ifdef IO_TIMEOUT_EN
            else begin
                m_wait++;
                if (m_wait == TIMEOUT) begin
                    void'(q.pop_front());
                    m_tmo  = 1'b1;
                    m_req  = 1'b0;
                    m_cool = 1;
                end
            end
`endif
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (q.size() > 0) begin
            m_req     = 1'b1;
            m_data_in = q[0];
            m_wait    = 0;
        end
        if (push) q.push_back(ext_data);
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".int"}, {31'd0, interrupt}, {31'd0, m_req});
        check_eq({tag, ".din"}, {16'd0, data_in}, {16'd0, m_data_in});
        check_eq({tag, ".cnt"}, {29'd0, fifo_count}, q.size());
        check_eq({tag, ".rdy"}, {31'd0, ext_ready}, {31'd0, q.size() < DEPTH});
        check_eq({tag, ".ovf"}, {31'd0, overflow}, {31'd0, m_ovf});
        check_eq({tag, ".tmo"}, {31'd0, timeout_err}, {31'd0, m_tmo});
        check_eq({tag, ".ov"}, {31'd0, out_valid}, {31'd0, m_ov});
        check_eq({tag, ".od"}, {16'd0, out_data}, {16'd0, m_od});
    endtask

    // Apply inputs, step the model, clock once and compare 1 time unit after the edge.
    task automatic cycle(input string tag, input logic v, input logic [15:0] d,
                         input logic ack, input logic we, input logic [15:0] dout);
        ext_valid = v;
        ext_data  = d;
        int_ack   = ack;
        out_we    = we;
        data_out  = dout;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        ext_valid = 1'b0;
        int_ack   = 1'b0;
        out_we    = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        reset = 1'b1;
    endtask

    initial begin
        int gap;
        reset     = 1'b0;
        ext_valid = 1'b0;
        ext_data  = '0;
        int_ack   = 1'b0;
        out_we    = 1'b0;
        data_out  = '0;
        model_reset();
        #12;
        check_all("rst");
        check_eq("rst.ready_is_1", {31'd0, ext_ready}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("rel");

        // single word: request one edge after the count becomes 1, then ack
        cycle("tp1.push", 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0);
        check_eq("tp1.cnt1", {29'd0, fifo_count}, 32'd1);
        check_eq("tp1.no_int_yet", {31'd0, interrupt}, 32'd0);
        cycle("tp1.req", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        check_eq("tp1.int", {31'd0, interrupt}, 32'd1);
        check_eq("tp1.din", {16'd0, data_in}, 32'h1234);
        cycle("tp1.ack", 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        check_eq("tp1.int_low", {31'd0, interrupt}, 32'd0);
        check_eq("tp1.cnt0", {29'd0, fifo_count}, 32'd0);
        check_eq("tp1.din_hold", {16'd0, data_in}, 32'h1234);
        cycle("tp1.gap", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);

        // fill, overflow, then deliver in order with gaps
        for (int i = 0; i < 4; i++) cycle("tp2.fill", 1'b1, 16'hA001 + 16'(i), 1'b0, 1'b0, 16'h0);
        check_eq("tp2.cnt4", {29'd0, fifo_count}, 32'd4);
        check_eq("tp2.ready0", {31'd0, ext_ready}, 32'd0);
        cycle("tp2.push5", 1'b1, 16'hA005, 1'b0, 1'b0, 16'h0);
        check_eq("tp2.ovf", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            gap = 0;
            while (!interrupt && gap < 10) begin
                cycle("tp2.wait", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
                gap++;
            end
            check_eq("tp2.req", {31'd0, interrupt}, 32'd1);
            check_eq("tp2.word", {16'd0, data_in}, 32'hA001 + i);
            if (i > 0) check_eq("tp2.gap_ge2", {31'd0, gap >= 2}, 32'd1);
            cycle("tp2.ack", 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        end
        check_eq("tp2.empty", {29'd0, fifo_count}, 32'd0);

        // full FIFO: push and ack together, push refused
        do_reset("tp3.rst");
        for (int i = 0; i < 4; i++) cycle("tp3.fill", 1'b1, 16'hC001 + 16'(i), 1'b0, 1'b0, 16'h0);
        check_eq("tp3.int", {31'd0, interrupt}, 32'd1);
        cycle("tp3.both", 1'b1, 16'hC005, 1'b1, 1'b0, 16'h0);
        check_eq("tp3.cnt3", {29'd0, fifo_count}, 32'd3);
        check_eq("tp3.ovf", {31'd0, overflow}, 32'd1);

        // core write path and ack while idle
        do_reset("tp4.rst");
        cycle("tp4.we1", 1'b0, 16'h0, 1'b0, 1'b1, 16'hBEEF);
        check_eq("tp4.ov1", {31'd0, out_valid}, 32'd1);
        check_eq("tp4.od1", {16'd0, out_data}, 32'hBEEF);
        cycle("tp4.we2", 1'b0, 16'h0, 1'b0, 1'b1, 16'h0042);
        check_eq("tp4.ov2", {31'd0, out_valid}, 32'd1);
        check_eq("tp4.od2", {16'd0, out_data}, 32'h0042);
        cycle("tp4.idle", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        check_eq("tp4.ov_off", {31'd0, out_valid}, 32'd0);
        cycle("tp4.ack_idle", 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        check_eq("tp4.no_int", {31'd0, interrupt}, 32'd0);
        check_eq("tp4.cnt", {29'd0, fifo_count}, 32'd0);

        // reset in the middle of a request
        cycle("tp5.p1", 1'b1, 16'h7001, 1'b0, 1'b0, 16'h0);
        cycle("tp5.p2", 1'b1, 16'h7002, 1'b0, 1'b0, 16'h0);
        check_eq("tp5.in_req", {31'd0, interrupt}, 32'd1);
        check_eq("tp5.cnt2", {29'd0, fifo_count}, 32'd2);
        do_reset("tp5.rst");
        for (int i = 0; i < 5; i++) cycle("tp5.quiet", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        check_eq("tp5.no_int", {31'd0, interrupt}, 32'd0);

`ifdef IO_TIMEOUT_EN
        // word dropped after TIMEOUT unacknowledged REQ cycles
        cycle("tp6.push", 1'b1, 16'h5555, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < TIMEOUT + 4; i++) cycle("tp6.wait", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        check_eq("tp6.tmo", {31'd0, timeout_err}, 32'd1);
        check_eq("tp6.cnt", {29'd0, fifo_count}, 32'd0);
        check_eq("tp6.int", {31'd0, interrupt}, 32'd0);
        do_reset("tp6.rst");
`endif

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rnd.rst");
            end else begin
                cycle("rnd",
                      1'($urandom_range(0, 1)),
                      16'($urandom),
                      1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 3) == 0),
                      16'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/io_int_responder.md
# io_int_responder

Peripheral-side responder for the 16-bit MIPS core's I/O and interrupt interface. External 16-bit words are buffered in a small FIFO and delivered to the core one at a time on `data_in`, each announced by raising `interrupt` and held until the core acknowledges it. The block also captures words the core writes on `data_out` into a registered output port for downstream logic. It sits between the core top level and off-chip I/O, as the device end of the core's interrupt/data port.

## Interface
- `DEPTH`, 4: FIFO depth in words; power of two, minimum 2.
- `PTR_W`, 2: log2(DEPTH).
- `TIMEOUT`, 255: maximum cycles in REQ before the word is dropped (only with `IO_TIMEOUT_EN`).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ext_data` in 16: word from external source.
- `ext_valid` in 1: `ext_data` is valid.
- `ext_ready` out 1: FIFO can accept a word; `!full`, combinational from the count.
- `data_in` out 16: word presented to the core (registered).
- `interrupt` out 1: request to the core (registered).
- `int_ack` in 1: core has consumed `data_in`.
- `data_out` in 16: word written by the core.
- `out_we` in 1: core write strobe for `data_out`.
- `out_data` out 16: last word written by the core (registered).
- `out_valid` out 1: one-cycle pulse, `out_data` updated.
- `fifo_count` out PTR_W+1: words held, 0..DEPTH.
- `overflow` out 1: sticky; a push was attempted while full.
- `timeout_err` out 1: sticky; a word was dropped on timeout (tied 0 without `IO_TIMEOUT_EN`).

## Operation
- Push: `ext_valid && ext_ready` writes `ext_data` at the write pointer. The write pointer and count increment, and pointers wrap modulo DEPTH.
- A push while full is refused and sets `overflow`. This holds even when a pop occurs in the same cycle, because `ext_ready` depends only on the current count.
- A simultaneous push and pop leaves the count unchanged.
- FSM states:
  - IDLE: `interrupt`=0. If the count is nonzero, load `data_in` from the FIFO head and go to REQ.
  - REQ: `interrupt`=1 and `data_in` is held stable. `int_ack`=1 pops the head and moves to GAP.
  - GAP: `interrupt`=0 for one cycle, then return to IDLE.
- `int_ack` outside REQ is ignored.
- `data_in` keeps its last value in IDLE and GAP.
- Core write: `out_we`=1 latches `data_out` into `out_data` and pulses `out_valid` on the next cycle. `out_we` on consecutive cycles produces consecutive pulses, with the last write winning. This path is independent of the FSM.
- Reset (asserted at any time, including mid-REQ) does the following immediately:
  - clears pointers, count, and FSM (to IDLE);
  - drives `data_in`, `out_data`, `interrupt`, `out_valid`, `overflow`, and `timeout_err` to 0;
  - discards any buffered words.

## Timing
- Reset values of all outputs are 0, except `ext_ready`=1 (FIFO empty).
- Push at edge N into an empty FIFO, with the FSM in IDLE:
  - `fifo_count`=1 after edge N;
  - `interrupt`=1 and `data_in` valid after edge N+1.
- Ack sampled high at edge M while in REQ:
  - `interrupt`=0 after edge M, and the count decrements at edge M;
  - the next request can rise no earlier than after edge M+2.
- `interrupt` is therefore low for at least 2 cycles between requests, giving the core a clean edge.
- Back-to-back words are delivered at most one every 3 cycles.
- `out_data` and `out_valid` update 1 cycle after `out_we`.

## Configuration
- `IO_TIMEOUT_EN` defined:
  - a counter of width ceil(log2(TIMEOUT+1)) resets on entry to REQ and increments each cycle in REQ without `int_ack`;
  - when it reaches TIMEOUT, the head is popped, `timeout_err` is set (sticky), and the FSM goes to GAP;
  - `int_ack` in the same cycle as the timeout counts as a normal ack and does not set `timeout_err`.
- `IO_TIMEOUT_EN` undefined: no counter, REQ waits indefinitely, and `timeout_err` is constant 0.

## Test plan
- Reset release, then push 0x1234 at edge N. Expect `interrupt`=1 and `data_in`=0x1234 after edge N+1. Ack one cycle later; expect `interrupt`=0 and `fifo_count`=0.
- Push 0xA001..0xA004 back-to-back with no ack. Expect `fifo_count`=4 and `ext_ready`=0. A fifth push of 0xA005 sets `overflow`=1. Ack four times; expect the words delivered in order 0xA001..0xA004 with `interrupt` low for at least 2 cycles between them.
- With the FIFO full, push and ack in the same cycle. Expect the push refused, the count to go 4→3, and `overflow` set.
- Pulse `out_we` with `data_out`=0xBEEF, then 0x0042 on the next cycle. Expect two `out_valid` pulses with `out_data` 0xBEEF then 0x0042. Pulse `int_ack` while in IDLE; expect no effect.
- Drive `reset` low mid-REQ with 2 words queued. Expect `interrupt`=0, `data_in`=0, `fifo_count`=0, and `overflow`=0 immediately. After release, expect no interrupt without a new push.
- With `IO_TIMEOUT_EN` and TIMEOUT=8: push 0x5555 and never ack. Expect the word dropped after 8 REQ cycles, `timeout_err`=1, `fifo_count`=0, and `interrupt`=0.
